// File: rtl/ps2_pkg.sv
// Shared types, byte constants and step-table helpers for the ASCII to PS/2 Set-2 encoder.
// PS2_ARROW_KEYS_EN adds the E0-prefixed EXTENDED byte sequence.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_LSHIFT = 8'h12;

    typedef enum logic [1:0] {NONE, PLAIN, SHIFTED, EXTENDED} key_class_t;

    typedef enum logic [1:0] {IDLE, LOAD, EMIT, GAP} enc_state_t;

    // Index of the final byte in the make/break sequence of a class.
    function automatic logic [2:0] last_step(input key_class_t cls);
        logic [2:0] last;
        last = 3'd0;
        case (cls)
            PLAIN:    last = 3'd2;
            SHIFTED:  last = 3'd5;
`ifdef PS2_ARROW_KEYS_EN
            EXTENDED: last = 3'd4;
`endif
            default:  last = 3'd0;
        endcase
        return last;
    endfunction

    function automatic logic [7:0] step_byte(input key_class_t cls, input logic [7:0] code,
                                             input logic [2:0] step);
        logic [7:0] b;
        b = 8'h00;
        case (cls)
            PLAIN: b = (step == 3'd1) ? PS2_BREAK : code;
            SHIFTED: begin
                case (step)
                    3'd0:    b = PS2_LSHIFT;
                    3'd2:    b = PS2_BREAK;
                    3'd4:    b = PS2_BREAK;
                    3'd5:    b = PS2_LSHIFT;
                    default: b = code;
                endcase
            end
`ifdef PS2_ARROW_KEYS_EN
            EXTENDED: begin
                case (step)
                    3'd0:    b = PS2_EXT;
                    3'd2:    b = PS2_EXT;
                    3'd3:    b = PS2_BREAK;
                    default: b = code;
                endcase
            end
`endif
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/ps2_ascii_encoder_if.sv
// Character-in / scancode-byte-out valid/ready bundle of the PS/2 ASCII encoder.
interface ps2_ascii_encoder_if;
    logic       in_valid;
    logic       in_ready;
    logic [6:0] in_char;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;

    modport master (output in_valid, in_char, out_ready, input in_ready, out_valid, out_byte);
    modport slave  (input in_valid, in_char, out_ready, output in_ready, out_valid, out_byte);
endinterface

// File: rtl/ps2_ascii_map.sv
// Combinational ASCII to Set-2 make code and key class lookup.
// PS2_ARROW_KEYS_EN maps DC1..DC4 onto the extended arrow keys.
module ps2_ascii_map
    import ps2_pkg::*;
(
    input  logic [6:0] ch,
    output logic [7:0] code,
    output key_class_t cls
);

    localparam logic [7:0] LETTER [26] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };
    localparam logic [7:0] DIGIT [10] = '{
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46
    };

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        code = 8'h00;
        cls  = NONE;
        if (ch >= 7'h61 && ch <= 7'h7A) begin
            code = LETTER[5'(ch - 7'h61)];
            cls  = PLAIN;
        end else if (ch >= 7'h41 && ch <= 7'h5A) begin
            code = LETTER[5'(ch - 7'h41)];
            cls  = SHIFTED;
        end else if (ch >= 7'h30 && ch <= 7'h39) begin
            code = DIGIT[4'(ch - 7'h30)];
            cls  = PLAIN;
        end else begin
            case (ch)
                7'h20: begin code = 8'h29; cls = PLAIN; end
                7'h0D: begin code = 8'h5A; cls = PLAIN; end
                7'h08: begin code = 8'h66; cls = PLAIN; end
`ifdef PS2_ARROW_KEYS_EN
                7'h11: begin code = 8'h6B; cls = EXTENDED; end
                7'h12: begin code = 8'h72; cls = EXTENDED; end
                7'h13: begin code = 8'h75; cls = EXTENDED; end
                7'h14: begin code = 8'h74; cls = EXTENDED; end
`endif
                default: begin code = 8'h00; cls = NONE; end
            endcase
        end
    end

endmodule

// File: rtl/ps2_ascii_encoder.sv
// Streaming ASCII to PS/2 Set-2 encoder: character FIFO, make/break sequencer and
// inter-byte gap timer driving a byte-wide valid/ready output.
module ps2_ascii_encoder
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    ps2_ascii_encoder_if.slave                 bus,
    output logic                               busy,
    output logic                               unmapped,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int GW = ($clog2(GAP_CYCLES + 1) > 1) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_RELOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [6:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;

    assign bus.in_ready = (count != CW'(FIFO_DEPTH));
    assign push         = bus.in_valid && bus.in_ready;

    // NOTE: storage is not reset; pointers and count alone say which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_char;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    logic [7:0] map_code;
    key_class_t map_cls;

    ps2_ascii_map u_map (
        .ch   (mem[rd_ptr]),
        .code (map_code),
        .cls  (map_cls)
    );

    enc_state_t    state, state_n;
    logic [7:0]    code_q, code_n;
    key_class_t    cls_q, cls_n;
    logic [2:0]    step_q, step_n;
    logic [GW-1:0] gap_q, gap_n;
    logic          valid_q, valid_n;
    logic [7:0]    byte_q, byte_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            code_q  <= 8'h00;
            cls_q   <= NONE;
            step_q  <= 3'd0;
            gap_q   <= '0;
            valid_q <= 1'b0;
            byte_q  <= 8'h00;
        end else begin
            state   <= state_n;
            code_q  <= code_n;
            cls_q   <= cls_n;
            step_q  <= step_n;
            gap_q   <= gap_n;
            valid_q <= valid_n;
            byte_q  <= byte_n;
        end
    end

    always_comb begin
        state_n  = state;
        code_n   = code_q;
        cls_n    = cls_q;
        step_n   = step_q;
        gap_n    = gap_q;
        valid_n  = valid_q;
        byte_n   = byte_q;
        pop      = 1'b0;
        unmapped = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    code_n  = map_code;
                    cls_n   = map_cls;
                    step_n  = 3'd0;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (cls_q == NONE) begin
                    unmapped = 1'b1;
                    state_n  = IDLE;
                end else begin
                    valid_n = 1'b1;
                    byte_n  = step_byte(cls_q, code_q, 3'd0);
                    state_n = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (GAP_CYCLES != 0) begin
                        valid_n = 1'b0;
                        gap_n   = GAP_RELOAD;
                        state_n = GAP;
                    end else if (step_q == last_step(cls_q)) begin
                        valid_n = 1'b0;
                        state_n = IDLE;
                    end else begin
                        step_n = step_q + 3'd1;
                        byte_n = step_byte(cls_q, code_q, step_q + 3'd1);
                    end
                end
            end
            GAP: begin
                // The step only advances once the gap expires, so the final byte also gets its gap.
                if (gap_q == '0) begin
                    if (step_q == last_step(cls_q)) begin
                        state_n = IDLE;
                    end else begin
                        step_n  = step_q + 3'd1;
                        byte_n  = step_byte(cls_q, code_q, step_q + 3'd1);
                        valid_n = 1'b1;
                        state_n = EMIT;
                    end
                end else begin
                    gap_n = gap_q - GW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.out_valid = valid_q;
    assign bus.out_byte  = byte_q;
    assign fifo_count    = count;
    assign busy          = (count != '0) || (state != IDLE);

endmodule

// File: tb/tb_ps2_ascii_encoder.sv
// Directed bench for ps2_ascii_encoder: one instance with back-to-back bytes, one with a 16-cycle gap.
module tb_ps2_ascii_encoder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ps2_ascii_encoder_if f0 ();
    ps2_ascii_encoder_if f16 ();

    logic       busy0, unm0, busy16, unm16;
    logic [2:0] cnt0, cnt16;

    ps2_ascii_encoder #(.FIFO_DEPTH(4), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(f0),
        .busy(busy0), .unmapped(unm0), .fifo_count(cnt0)
    );

    ps2_ascii_encoder #(.FIFO_DEPTH(4), .GAP_CYCLES(16)) dut16 (
        .clk(clk), .reset(reset), .bus(f16),
        .busy(busy16), .unmapped(unm16), .fifo_count(cnt16)
    );

    int checks = 0;
    int failures = 0;
    int unm_pulses0 = 0;

    always @(negedge clk) if (unm0 === 1'b1) unm_pulses0++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with out_ready high; returns at the negedge after the handshake.
    task automatic get_byte(input bit sel, output logic [7:0] b, output int waited);
        waited = 0;
        b = 'x;
        while (((sel ? f16.out_valid : f0.out_valid) !== 1'b1) && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if ((sel ? f16.out_valid : f0.out_valid) !== 1'b1) begin
            waited = -1;
        end else begin
            b = sel ? f16.out_byte : f0.out_byte;
            @(negedge clk);
        end
    endtask

    task automatic expect_seq(input bit sel, input string tag, input logic [47:0] seq,
                              input int n, input int first_wait, input int gap);
        logic [7:0] b;
        int w;
        for (int i = 0; i < n; i++) begin
            get_byte(sel, b, w);
            check($sformatf("%s_byte%0d", tag, i), {24'h0, b}, {24'h0, seq[47-8*i -: 8]});
            if (i == 0 && first_wait >= 0) check($sformatf("%s_latency", tag), w, first_wait);
            else if (i > 0) check($sformatf("%s_gap%0d", tag, i), w, gap);
        end
    endtask

    task automatic push(input bit sel, input logic [6:0] ch);
        if (sel) begin f16.in_valid = 1'b1; f16.in_char = ch; end
        else     begin f0.in_valid  = 1'b1; f0.in_char  = ch; end
        @(negedge clk);
        f0.in_valid  = 1'b0;
        f16.in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] chs, codes;
        logic [7:0]  c, k;
        int          u;

        reset = 1'b1;
        f0.in_valid = 1'b0;  f0.in_char = 7'h0;  f0.out_ready = 1'b1;
        f16.in_valid = 1'b0; f16.in_char = 7'h0; f16.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", f0.in_ready, 1);
        check("rst_out_valid", f0.out_valid, 0);
        check("rst_out_byte", f0.out_byte, 8'h00);
        check("rst_busy", busy0, 0);
        check("rst_unmapped", unm0, 0);
        check("rst_count", cnt0, 0);
        check("rst_out_valid16", f16.out_valid, 0);
        reset = 1'b0;
        @(negedge clk);

        // Lower-case letter, back-to-back bytes
        push(0, 7'h61);
        check("a_count", cnt0, 1);
        check("a_busy", busy0, 1);
        expect_seq(0, "a", 48'h1CF01C000000, 3, 2, 0);
        check("a_busy_done", busy0, 0);

        // Upper-case letter with 16-cycle gaps, including after the last byte
        push(1, 7'h51);
        expect_seq(1, "Q", 48'h1215F015F012, 6, 2, 16);
        repeat (15) @(negedge clk);
        check("Q_busy_in_final_gap", busy16, 1);
        @(negedge clk);
        check("Q_busy_done", busy16, 0);

        // Unmapped character followed by a mapped one
        u = unm_pulses0;
        f0.in_valid = 1'b1; f0.in_char = 7'h23;
        @(negedge clk);
        f0.in_char = 7'h62;
        @(negedge clk);
        f0.in_valid = 1'b0;
        check("hash_unmapped", unm0, 1);
        expect_seq(0, "b", 48'h32F032000000, 3, -1, 0);
        check("hash_pulses", unm_pulses0 - u, 1);

        // Digits, space, CR, BS and the last letter
        chs   = 48'h3039200D087A;
        codes = 48'h4546295A661A;
        for (int i = 0; i < 6; i++) begin
            c = chs[47-8*i -: 8];
            k = codes[47-8*i -: 8];
            push(0, c[6:0]);
            expect_seq(0, $sformatf("ch%02h", c), {k, 8'hF0, k, 24'h0}, 3, 2, 0);
        end

        // FIFO fill with the output stalled
        f0.out_ready = 1'b0;
        f0.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            f0.in_char = 7'h61 + 7'(i);
            @(negedge clk);
            if (i == 1) check("fifo_pushpop_count", cnt0, 1);
        end
        check("fifo_full_count", cnt0, 4);
        check("fifo_full_in_ready", f0.in_ready, 0);
        f0.in_char = 7'h66;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("stall_valid%0d", i), f0.out_valid, 1);
            check($sformatf("stall_byte%0d", i), f0.out_byte, 8'h1C);
            check($sformatf("stall_count%0d", i), cnt0, 4);
        end
        f0.in_valid = 1'b0;
        f0.out_ready = 1'b1;
        expect_seq(0, "drain_a", 48'h1CF01C000000, 3, 0, 0);
        check("drain_count_after_a", cnt0, 4);
        expect_seq(0, "drain_b", 48'h32F032000000, 3, 2, 0);
        expect_seq(0, "drain_c", 48'h21F021000000, 3, 2, 0);
        expect_seq(0, "drain_d", 48'h23F023000000, 3, 2, 0);
        expect_seq(0, "drain_e", 48'h24F024000000, 3, 2, 0);
        check("drain_count", cnt0, 0);
        check("drain_busy", busy0, 0);

        // Reset in the middle of 'Z' with 'x' still queued
        push(0, 7'h5A);
        push(0, 7'h78);
        expect_seq(0, "Z", 48'h121A00000000, 2, -1, 0);
        check("Z_byte2_valid", f0.out_valid, 1);
        check("Z_byte2", f0.out_byte, 8'hF0);
        check("Z_queued", cnt0, 1);
        reset = 1'b1;
        #1;
        check("midrst_out_valid", f0.out_valid, 0);
        check("midrst_out_byte", f0.out_byte, 8'h00);
        check("midrst_busy", busy0, 0);
        check("midrst_count", cnt0, 0);
        check("midrst_in_ready", f0.in_ready, 1);
        check("midrst_unmapped", unm0, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("flushed_valid%0d", i), f0.out_valid, 0);
        end
        push(0, 7'h7A);
        expect_seq(0, "z_after_rst", 48'h1AF01A000000, 3, 2, 0);

        // Arrow key (DC3)
        u = unm_pulses0;
        push(0, 7'h13);
`ifdef PS2_ARROW_KEYS_EN
        expect_seq(0, "arrow", 48'hE075E0F07500, 5, 2, 0);
        check("arrow_unmapped", unm_pulses0 - u, 0);
`else
        for (int i = 0; i < 8; i++) begin
            check($sformatf("arrow_no_byte%0d", i), f0.out_valid, 0);
            @(negedge clk);
        end
        check("arrow_unmapped", unm_pulses0 - u, 1);
`endif
        check("end_busy", busy0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
